// File: rtl/hex_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : hex_display_scan
// Description : Memory-mapped hex display scanner. The CPU writes a 32-bit
//               value into a shadow register; the value is copied to the
//               displayed (active) register only at a scan-frame boundary, so
//               one frame never mixes old and new nibbles. Nibbles of the
//               active value are time-multiplexed onto a shared 4-bit digit
//               bus with a one-hot, active-low digit enable vector.
//               Register map: addr 0 = VALUE, addr 1 = CTRL
//               CTRL: bit0 en (reset 1), bit1 hold (reset 0),
//                     bit2 lzb (reset 1, only with HEX_DISP_LZB_EN).
// Options     : define HEX_DISP_LZB_EN to enable leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_display_scan #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  addr,
    input  logic [31:0]           wr_data,
    output logic [31:0]           rd_data,
    output logic [3:0]            digit,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic [2:0]            digit_idx
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                     c_div_w    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_div_w-1:0]     c_div_last = c_div_w'(SCAN_DIV - 1);
    localparam logic [2:0]             c_idx_last = 3'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0]  c_one      = NUM_DIGITS'(1);

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [31:0]           r_shadow;
    logic [31:0]           r_active;
    logic                  r_pending;
    logic                  r_en;
    logic                  r_hold;
    logic [c_div_w-1:0]    r_div;
    logic [2:0]            r_idx;

    logic                  w_wr_value;
    logic                  w_wr_ctrl;
    logic                  w_div_tc;
    logic                  w_frame;
    logic                  w_load;
    logic                  w_blank;
    logic                  w_lzb_bit;
    logic [3:0]            w_nibble;
    logic [NUM_DIGITS-1:0] w_onehot;

    // ------------------------------------------------------------------------
    // Decode and scan timing
    // ------------------------------------------------------------------------
    assign w_wr_value = wr_en && !addr;
    assign w_wr_ctrl  = wr_en &&  addr;
    assign w_div_tc   = (r_div == c_div_last);
    // A frame ends on the last divider cycle of the last digit.
    assign w_frame    = w_div_tc && (r_idx == c_idx_last);
    // Shadow-to-active copy happens only at a frame edge and never while held.
    assign w_load     = w_frame && r_pending && !r_hold;

    // Control register: enable and hold bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en   <= 1'b1;
            r_hold <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_en   <= wr_data[0];
            r_hold <= wr_data[1];
        end
    end

`ifdef HEX_DISP_LZB_EN
    logic       r_lzb;
    logic [7:0] w_upper_zero;

    // Run-time leading-zero blanking switch, CTRL bit2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lzb <= 1'b1;
        end else if (w_wr_ctrl) begin
            r_lzb <= wr_data[2];
        end
    end

    // w_upper_zero[i] is set when digit i and every digit above it are zero.
    // Digit 0 is never blanked, and slots beyond NUM_DIGITS never occur.
    for (genvar gi = 0; gi < 8; gi++) begin : g_upper_zero
        if ((gi > 0) && (gi < NUM_DIGITS)) begin : g_live
            assign w_upper_zero[gi] = (r_active[4*NUM_DIGITS-1:4*gi] == '0);
        end else begin : g_none
            assign w_upper_zero[gi] = 1'b0;
        end
    end

    assign w_blank   = r_lzb && w_upper_zero[r_idx];
    assign w_lzb_bit = r_lzb;
`else
    assign w_blank   = 1'b0;
    assign w_lzb_bit = 1'b0;
`endif

    // Divider counts the dwell time of each digit; the digit index advances
    // on its terminal count and wraps after the last configured digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
            r_idx <= 3'd0;
        end else if (w_div_tc) begin
            r_div <= '0;
            r_idx <= (r_idx == c_idx_last) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Double buffer. The VALUE write is evaluated after the frame-edge load so
    // a write landing on the boundary keeps pending set (set beats clear),
    // while the active register still takes the pre-write shadow contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow  <= 32'd0;
            r_active  <= 32'd0;
            r_pending <= 1'b0;
        end else begin
            if (w_load) begin
                r_active  <= r_shadow;
                r_pending <= 1'b0;
            end
            if (w_wr_value) begin
                r_shadow  <= wr_data;
                r_pending <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Display outputs
    // ------------------------------------------------------------------------
    assign w_nibble = r_active[{r_idx, 2'b00} +: 4];
    assign w_onehot = c_one << r_idx;

    // Registered digit bus and enables; disabled or blanked slots go dark
    // while the nibble and index keep following the scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit     <= 4'd0;
            digit_idx <= 3'd0;
            an_n      <= '1;
        end else begin
            digit     <= w_nibble;
            digit_idx <= r_idx;
            an_n      <= (r_en && !w_blank) ? ~w_onehot : '1;
        end
    end

    // Read mux: VALUE returns what is on the display, not the shadow.
    always_comb begin
        rd_data = r_active;
        if (addr) begin
            rd_data = {29'd0, w_lzb_bit, r_hold, r_en};
        end
    end

endmodule
`default_nettype wire
